// File: rtl/fetch_unit.sv
// Instruction fetch unit: a combinational-read instruction memory feeds a small
// prefetch FIFO; the decoder consumes the head under a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_fetch_en,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_instr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [2:0]  o_count
);

    localparam int         PTR_W   = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [31:0]      fetch_pc_reg;
    logic [2:0]       count_reg;
    logic [2:0]       count_next;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic             pop;
    logic             push;
    logic             not_empty;

    assign not_empty = (count_reg != 3'd0);
    assign pop       = not_empty & i_ready;
    assign push      = i_fetch_en & ~i_redirect & ((count_reg < DEPTH_C) | pop);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
    end

    // Redirect wins over everything: flush the buffer and restart at the new PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg <= RESET_PC;
            count_reg    <= 3'd0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else if (i_redirect) begin
            fetch_pc_reg <= i_redirect_pc;
            count_reg    <= 3'd0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                fetch_pc_reg <= fetch_pc_reg + PC_INC;
                tail_reg     <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
        end
    end

    // Entry storage needs no reset; the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_reg]    <= fetch_pc_reg;
            instr_mem[tail_reg] <= i_imem_instr;
        end
    end

    assign o_imem_addr = fetch_pc_reg;
    assign o_valid     = not_empty;
    assign o_count     = count_reg;
    assign o_pc        = not_empty ? pc_mem[head_reg]    : 32'd0;
    assign o_instr     = not_empty ? instr_mem[head_reg] : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2): streaming, backpressure, redirect,
// address wrap, fetch disable and asynchronous reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_fetch_en;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_instr;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [2:0]  o_count;

    int n_pass = 0;
    int n_total = 0;

    fetch_unit #(.RESET_PC(32'h0), .PC_INC(32'd4), .DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_fetch_en   (i_fetch_en),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_addr  (o_imem_addr),
        .i_imem_instr (i_imem_instr),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: word k (address 4k) holds k.
    assign i_imem_instr = o_imem_addr >> 2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        i_fetch_en    = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_ready       = 1'b0;
        #1;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_count", {29'd0, o_count}, 32'd0);
        check("rst_addr", o_imem_addr, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check("rst_instr", o_instr, 32'h0);

        // Streaming: one word per cycle, count steady at 1.
        @(negedge clk);
        reset      = 1'b1;
        i_fetch_en = 1'b1;
        i_ready    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stream_pc%0d", k), o_pc, 32'(4 * k));
            check($sformatf("stream_instr%0d", k), o_instr, 32'(k));
            check($sformatf("stream_count%0d", k), {29'd0, o_count}, 32'd1);
            $display("stream k=%0d pc=%h instr=%h count=%0d", k, o_pc, o_instr, o_count);
        end

        // Asynchronous reset between edges.
        #2;
        reset   = 1'b0;
        i_ready = 1'b0;
        #1;
        check("areset_valid", {31'd0, o_valid}, 32'd0);
        check("areset_count", {29'd0, o_count}, 32'd0);
        check("areset_pc", o_pc, 32'h0);
        check("areset_instr", o_instr, 32'h0);
        check("areset_addr", o_imem_addr, 32'h0);
        $display("async reset addr=%h valid=%0d", o_imem_addr, o_valid);

        // Backpressure: decoder stalls for 5 cycles, head held.
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("stall_count%0d", c), {29'd0, o_count}, (c == 0) ? 32'd1 : 32'd2);
            check($sformatf("stall_pc%0d", c), o_pc, 32'h0);
            $display("stall c=%0d pc=%h count=%0d addr=%h", c, o_pc, o_count, o_imem_addr);
        end
        check("stall_addr", o_imem_addr, 32'h8);
        check("stall_valid", {31'd0, o_valid}, 32'd1);
        i_ready = 1'b1;
        tick();
        check("release_pc4", o_pc, 32'h4);
        check("release_instr1", o_instr, 32'h1);
        check("release_count", {29'd0, o_count}, 32'd2);
        tick();
        check("release_pc8", o_pc, 32'h8);
        check("release_instr2", o_instr, 32'h2);
        $display("released pc=%h count=%0d", o_pc, o_count);

        // Redirect while full (with a concurrent pop).
        check("pre_redir_count", {29'd0, o_count}, 32'd2);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        tick();
        i_redirect = 1'b0;
        check("redir_valid", {31'd0, o_valid}, 32'd0);
        check("redir_count", {29'd0, o_count}, 32'd0);
        check("redir_addr", o_imem_addr, 32'h100);
        tick();
        check("redir_pc", o_pc, 32'h100);
        check("redir_instr", o_instr, 32'h40);
        $display("redirect pc=%h instr=%h", o_pc, o_instr);

        // Address wrap through 2^32.
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFF8;
        tick();
        i_redirect = 1'b0;
        check("wrap_addr", o_imem_addr, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc0", o_pc, 32'hFFFF_FFF8);
        check("wrap_instr0", o_instr, 32'h3FFF_FFFE);
        tick();
        check("wrap_pc1", o_pc, 32'hFFFF_FFFC);
        check("wrap_instr1", o_instr, 32'h3FFF_FFFF);
        tick();
        check("wrap_pc2", o_pc, 32'h0);
        check("wrap_instr2", o_instr, 32'h0);
        check("wrap_addr_after", o_imem_addr, 32'h4);
        $display("wrap pc=%h addr=%h", o_pc, o_imem_addr);

        // Fetch disable: fill to 2, then drain with no new fetches.
        i_ready = 1'b0;
        tick();
        check("fill_count", {29'd0, o_count}, 32'd2);
        check("fill_addr", o_imem_addr, 32'h8);
        i_fetch_en = 1'b0;
        i_ready    = 1'b1;
        tick();
        check("drain_pc", o_pc, 32'h4);
        check("drain_count1", {29'd0, o_count}, 32'd1);
        tick();
        check("drain_valid", {31'd0, o_valid}, 32'd0);
        check("drain_count0", {29'd0, o_count}, 32'd0);
        check("drain_pc_zero", o_pc, 32'h0);
        tick();
        check("drain_addr", o_imem_addr, 32'h8);
        check("drain_idle_valid", {31'd0, o_valid}, 32'd0);
        $display("drained addr=%h valid=%0d", o_imem_addr, o_valid);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have parameter PC_INC, default 4, the fetch-address increment per fetched word.
REQ-003 SHALL have parameter DEPTH, default 2, the prefetch-buffer entry count; legal values are 2 and 4.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low (0 = in reset).
REQ-006 SHALL have port i_fetch_en  input  1  permits new fetches when 1.
REQ-007 SHALL have port i_redirect  input  1  flush and restart fetch at i_redirect_pc.
REQ-008 SHALL have port i_redirect_pc  input  32  new fetch address.
REQ-009 SHALL have port o_imem_addr  output  32  address to instruction memory (combinational read).
REQ-010 SHALL have port i_imem_instr  input  32  word returned for o_imem_addr in the same cycle.
REQ-011 SHALL have port o_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port i_ready  input  1  decoder accepts head this cycle.
REQ-013 SHALL have port o_instr  output  32  head instruction.
REQ-014 SHALL have port o_pc  output  32  address of head instruction.
REQ-015 SHALL have port o_count  output  3  entries currently buffered.

Function
REQ-016 SHALL hold a 32-bit fetch_pc register; o_imem_addr = fetch_pc at all times.
REQ-017 SHALL define pop = o_valid & i_ready; push = i_fetch_en & ~i_redirect & (count < DEPTH | pop).
REQ-018 SHALL on push write {fetch_pc, i_imem_instr} to the buffer tail and set fetch_pc <= fetch_pc + PC_INC, modulo 2^32 (0xFFFF_FFFC + 4 -> 0x0000_0000).
REQ-019 SHALL on pop advance the head; simultaneous push and pop leaves count unchanged, including when full.
REQ-020 SHALL keep o_valid = (count != 0); o_instr/o_pc driven from the head entry, zero when empty.
REQ-021 SHALL give fetch-to-output latency of one cycle: a word pushed at edge N is visible at o_instr after edge N when the buffer was empty.
REQ-022 SHALL hold head stable (o_instr, o_pc, o_valid) while o_valid & ~i_ready.
REQ-023 SHALL on i_redirect give redirect priority: at the edge, count <= 0, all entries invalidated, fetch_pc <= i_redirect_pc, no push; a pop in the same cycle counts as consumed.
REQ-024 SHALL with i_fetch_en = 0 stop pushes and hold fetch_pc while the buffer still drains via pops.
REQ-025 SHALL never overflow (push blocked when full with no pop) and never underflow (pop impossible when empty).
REQ-026 SHALL update o_count registered, equal to entries after each edge, range 0..DEPTH.

Reset
REQ-027 SHALL on reset = 0 immediately (asynchronously) set fetch_pc = RESET_PC, count = 0, o_valid = 0, o_instr = 0, o_pc = 0, o_count = 0.
REQ-028 SHALL discard all in-flight buffer contents on reset asserted mid-operation; first push after release occurs at the first rising edge with reset = 1 and i_fetch_en = 1.

Verification
REQ-029 SHALL cover streaming: reset release, i_fetch_en = 1, i_ready = 1, imem[k] = k -> o_pc 0,4,8,... on consecutive cycles, o_instr matching, o_count steady at 1.
REQ-030 SHALL cover backpressure: i_ready = 0 for 5 cycles (DEPTH = 2) -> o_count reaches 2, fetch_pc frozen at 8, head o_pc = 0 held; i_ready = 1 -> o_pc 0,4,8 with no gap or duplicate.
REQ-031 SHALL cover redirect while full: count = 2, i_redirect = 1, i_redirect_pc = 0x100 -> next cycle o_valid = 0, o_count = 0, o_imem_addr = 0x100; the following cycle o_pc = 0x100.
REQ-032 SHALL cover wrap: i_redirect_pc = 0xFFFF_FFF8 -> delivered o_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-033 SHALL cover fetch disable: i_fetch_en = 0 with 2 buffered, i_ready = 1 -> 2 pops, then o_valid = 0, o_imem_addr unchanged.
REQ-034 SHALL cover async reset mid-stream: reset = 0 between clock edges -> outputs zero and o_imem_addr = RESET_PC before the next edge.
